// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage
//    Fetch stage that sits directly in front of the main decoder. It holds the
//    PC and a small word-addressed instruction memory. Each fetched word and
//    its PC+4 are registered into the IF/ID slot. The slot can be held
//    (stall) or flushed and redirected (branch).
//
// Ports
//    clk            clock; all state updates on the rising edge
//    rst            synchronous active-high reset
//    stall          hold the PC and the IF/ID slot
//    branch_taken   redirect fetch to branch_target and flush the IF/ID slot
//    branch_target  redirect address; bits [1:0] are forced to zero
//    imem_we        instruction memory write enable (program load)
//    imem_waddr     word index to write
//    imem_wdata     instruction word to write
//    pc             current fetch address
//    if_id_instr    registered instruction
//    if_id_pc4      registered PC+4 of that instruction
//    if_id_valid    the slot holds a real instruction
//    opcode         if_id_instr[31:26], sent to the decoder
module instr_fetch_stage #(
   parameter int          IMEM_DEPTH = 64,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stall,
   input  logic                          branch_taken,
   input  logic [31:0]                   branch_target,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
   input  logic [31:0]                   imem_wdata,
   output logic [31:0]                   pc,
   output logic [31:0]                   if_id_instr,
   output logic [31:0]                   if_id_pc4,
   output logic                          if_id_valid,
   output logic [5:0]                    opcode
);

   localparam int AW = $clog2(IMEM_DEPTH);

   logic [31:0] imem [IMEM_DEPTH];
   logic [31:0] fetch_word;
   logic [31:0] pc_plus4;

   // The read is combinational. The PC bits above the index are ignored,
   // so fetch addresses wrap modulo the memory size.
   assign fetch_word = imem[pc[2 +: AW]];
   assign pc_plus4   = pc + 32'd4;
   assign opcode     = if_id_instr[31:26];

   // The memory is not reset, and writes ignore rst, stall and branch.
   // Fetch reads the array before this edge updates it, so a fetch that
   // reads the word being written gets the old contents.
   always_ff @(posedge clk) begin
      if (imem_we) begin
         imem[imem_waddr] <= imem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         if_id_instr <= 32'd0;
         if_id_pc4   <= 32'd0;
         if_id_valid <= 1'b0;
      end else if (branch_taken) begin
         // A branch beats a stall. The slot is flushed to an all-zero word.
         pc          <= branch_target & ~32'd3;
         if_id_instr <= 32'd0;
         if_id_pc4   <= 32'd0;
         if_id_valid <= 1'b0;
      end else if (!stall) begin
         pc          <= pc_plus4;
         if_id_instr <= fetch_word;
         if_id_pc4   <= pc_plus4;
         if_id_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_we;
   logic [5:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic [5:0]  opcode;

   int checks = 0;
   int errors = 0;

   instr_fetch_stage #(.IMEM_DEPTH(64), .RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_we       (imem_we),
      .imem_waddr    (imem_waddr),
      .imem_wdata    (imem_wdata),
      .pc            (pc),
      .if_id_instr   (if_id_instr),
      .if_id_pc4     (if_id_pc4),
      .if_id_valid   (if_id_valid),
      .opcode        (opcode)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_slot(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_valid);
      check({tag, " pc"},     pc,                  e_pc);
      check({tag, " instr"},  if_id_instr,         e_instr);
      check({tag, " pc4"},    if_id_pc4,           e_pc4);
      check({tag, " valid"},  {31'd0, if_id_valid}, {31'd0, e_valid});
      check({tag, " opcode"}, {26'd0, opcode},     {26'd0, e_instr[31:26]});
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
      imem_we = 1'b0; imem_waddr = 6'd0; imem_wdata = 32'd0;
      #1;

      // Program load while reset is held; writes do not depend on rst.
      imem_we = 1'b1; imem_waddr = 6'd0;  imem_wdata = 32'h8C01_0004; step();
      check_slot("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      imem_waddr = 6'd1;  imem_wdata = 32'hAC01_0008; step();
      imem_waddr = 6'd2;  imem_wdata = 32'h1000_0002; step();
      imem_waddr = 6'd3;  imem_wdata = 32'h0022_1820; step();
      imem_waddr = 6'd63; imem_wdata = 32'h3C00_0063; step();
      check_slot("reset held", 32'h0, 32'h0, 32'h0, 1'b0);
      imem_we = 1'b0;

      // Sequential fetch
      rst = 1'b0; step();
      check_slot("seq0", 32'h4, 32'h8C01_0004, 32'h4, 1'b1);
      step();
      check_slot("seq1", 32'h8, 32'hAC01_0008, 32'h8, 1'b1);

      // Stall for three cycles: everything holds
      stall = 1'b1;
      step(); check_slot("stall1", 32'h8, 32'hAC01_0008, 32'h8, 1'b1);
      step(); check_slot("stall2", 32'h8, 32'hAC01_0008, 32'h8, 1'b1);
      step(); check_slot("stall3", 32'h8, 32'hAC01_0008, 32'h8, 1'b1);
      stall = 1'b0;
      step(); check_slot("resume", 32'hC, 32'h1000_0002, 32'hC, 1'b1);

      // Branch to an unaligned target: low bits are dropped and the slot is flushed
      branch_taken = 1'b1; branch_target = 32'h0000_0006;
      step(); check_slot("branch flush", 32'h4, 32'h0, 32'h0, 1'b0);
      branch_taken = 1'b0;
      step(); check_slot("branch refill", 32'h8, 32'hAC01_0008, 32'h8, 1'b1);

      // Branch and stall together: the branch wins
      branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h0;
      step(); check_slot("br+stall", 32'h0, 32'h0, 32'h0, 1'b0);
      branch_taken = 1'b0; stall = 1'b0;
      step(); check_slot("br+stall refill", 32'h4, 32'h8C01_0004, 32'h4, 1'b1);

      // Index wrap: pc 0x100 reads imem[0]
      branch_taken = 1'b1; branch_target = 32'h0000_0100;
      step(); check_slot("to 0x100", 32'h100, 32'h0, 32'h0, 1'b0);
      branch_taken = 1'b0;
      step(); check_slot("wrap fetch", 32'h104, 32'h8C01_0004, 32'h104, 1'b1);

      // Read during write to the same word: old contents captured
      branch_taken = 1'b1; branch_target = 32'h0;
      step(); check_slot("to 0", 32'h0, 32'h0, 32'h0, 1'b0);
      branch_taken = 1'b0;
      imem_we = 1'b1; imem_waddr = 6'd0; imem_wdata = 32'hDEAD_BEEF;
      step(); check_slot("rdw old", 32'h4, 32'h8C01_0004, 32'h4, 1'b1);
      imem_we = 1'b0;
      branch_taken = 1'b1; branch_target = 32'h0;
      step(); check_slot("refetch br", 32'h0, 32'h0, 32'h0, 1'b0);
      branch_taken = 1'b0;
      step(); check_slot("rdw new", 32'h4, 32'hDEAD_BEEF, 32'h4, 1'b1);

      // PC+4 wraps at the top of the address space
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
      step(); check_slot("to top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
      branch_taken = 1'b0;
      step(); check_slot("pc wrap", 32'h0, 32'h3C00_0063, 32'h0, 1'b1);
      step(); check_slot("after wrap", 32'h4, 32'hDEAD_BEEF, 32'h4, 1'b1);

      // Reset beats both branch and stall
      rst = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0040;
      step(); check_slot("reset mid-run", 32'h0, 32'h0, 32'h0, 1'b0);
      rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      step(); check_slot("post reset", 32'h4, 32'hDEAD_BEEF, 32'h4, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
